// File: rtl/VX_gpu_pkg.sv
// Shared GPU-level types used by the per-port memory throttles.
// Contents:
//   drain_state_e : 2-bit state of the memory-port drain handshake
//                   (IDLE -> DRAIN -> DONE -> IDLE).
package VX_gpu_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,  // normal operation, requests flow
    DRAIN_WAIT = 2'd1,  // new requests blocked, waiting for credits to return
    DRAIN_DONE = 2'd2   // port quiesced, drain_ack asserted
  } drain_state_e;

endpackage

// File: rtl/VX_credit_counter.sv
// Up/down credit counter with a ceiling and underflow detection.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   inc        : take one credit (ignored when already at MAX)
//   dec        : return one credit (at zero: count holds, underflow sets)
//   count      : credits currently in use
//   full       : count == MAX
//   underflow  : sticky, set by a return seen at zero; cleared by reset only
module VX_credit_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  assign full = (count == MAX_C);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      // A return with nothing outstanding is an upstream protocol error;
      // flag it even if a new issue lands in the same cycle.
      if (dec && (count == '0)) begin
        underflow <= 1'b1;
      end
      // Simultaneous take and return cancel out.
      if (inc && !dec && !full) begin
        count <= count + 1'b1;
      end else if (dec && !inc && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_mem_credit_gate.sv
// Flow-control stage between an L1 memory port and the L2/memory arbiter.
// Limits outstanding reads to MAX_PENDING, returns a credit on each
// response delivered upstream, and offers a drain/ack handshake.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_in_*  / req_in_ready  : request from the socket side
//   req_out_* / req_out_ready : request toward L2 (combinational pass-through)
//   rsp_in_*  / rsp_in_ready  : read response from L2
//   rsp_out_* / rsp_out_ready : response toward the socket (pass-through)
//   drain_req / drain_ack     : quiesce request and acknowledgement
//   pending_count             : reads currently outstanding
//   stall_cycles              : saturating count of cycles a read waited on credit
//   underflow_err             : sticky, response returned with no read outstanding
//   busy                      : reads outstanding or a request waiting at the input
module vx_mem_credit_gate
  import VX_gpu_pkg::*;
#(
  parameter int DATA_SIZE   = 64,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req_in_valid,
  input  logic                   req_in_rw,
  input  logic [ADDR_WIDTH-1:0]  req_in_addr,
  input  logic [DATA_SIZE*8-1:0] req_in_data,
  input  logic [DATA_SIZE-1:0]   req_in_byteen,
  input  logic [TAG_WIDTH-1:0]   req_in_tag,
  output logic                   req_in_ready,

  output logic                   req_out_valid,
  output logic                   req_out_rw,
  output logic [ADDR_WIDTH-1:0]  req_out_addr,
  output logic [DATA_SIZE*8-1:0] req_out_data,
  output logic [DATA_SIZE-1:0]   req_out_byteen,
  output logic [TAG_WIDTH-1:0]   req_out_tag,
  input  logic                   req_out_ready,

  input  logic                   rsp_in_valid,
  input  logic [DATA_SIZE*8-1:0] rsp_in_data,
  input  logic [TAG_WIDTH-1:0]   rsp_in_tag,
  output logic                   rsp_in_ready,

  output logic                   rsp_out_valid,
  output logic [DATA_SIZE*8-1:0] rsp_out_data,
  output logic [TAG_WIDTH-1:0]   rsp_out_tag,
  input  logic                   rsp_out_ready,

  input  logic                   drain_req,
  output logic                   drain_ack,

  output logic [CNT_W-1:0]       pending_count,
  output logic [31:0]            stall_cycles,
  output logic                   underflow_err,
  output logic                   busy
);

  drain_state_e drain_state, drain_state_n;
  logic         cnt_full;
  logic         block;
  logic         issue_rd;
  logic         ret;
  logic         credit_stall;

  // ---------------- request gate ----------------
  // block depends only on registered state and request fields, never on
  // ready, so req_out_valid stays independent of req_out_ready.
  assign block         = (drain_state != DRAIN_IDLE) || (!req_in_rw && cnt_full);
  assign req_out_valid = req_in_valid & ~block;
  assign req_in_ready  = req_out_ready & ~block;

  assign req_out_rw     = req_in_rw;
  assign req_out_addr   = req_in_addr;
  assign req_out_data   = req_in_data;
  assign req_out_byteen = req_in_byteen;
  assign req_out_tag    = req_in_tag;

  // ---------------- response pass-through ----------------
  assign rsp_out_valid = rsp_in_valid;
  assign rsp_out_data  = rsp_in_data;
  assign rsp_out_tag   = rsp_in_tag;
  assign rsp_in_ready  = rsp_out_ready;

  // ---------------- credits ----------------
  assign issue_rd = req_out_valid & req_out_ready & ~req_in_rw;
  assign ret      = rsp_out_valid & rsp_out_ready;

  VX_credit_counter #(
    .MAX (MAX_PENDING),
    .W   (CNT_W)
  ) u_credit_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (issue_rd),
    .dec       (ret),
    .count     (pending_count),
    .full      (cnt_full),
    .underflow (underflow_err)
  );

  // ---------------- stall perf counter ----------------
  // Counts only credit stalls; cycles blocked by a drain are not stalls.
  assign credit_stall = req_in_valid & ~req_in_rw & cnt_full & (drain_state == DRAIN_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (credit_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_state <= DRAIN_IDLE;
    end else begin
      drain_state <= drain_state_n;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    drain_state_n = drain_state;
    drain_ack     = 1'b0;
    unique case (drain_state)
      DRAIN_IDLE: begin
        if (drain_req) drain_state_n = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        // An abandoned drain returns to IDLE without ever acknowledging.
        if (!drain_req) begin
          drain_state_n = DRAIN_IDLE;
        end else if ((pending_count == '0) && !ret) begin
          drain_state_n = DRAIN_DONE;
        end
      end
      DRAIN_DONE: begin
        drain_ack = 1'b1;
        if (!drain_req) drain_state_n = DRAIN_IDLE;
      end
      default: begin
        drain_state_n = DRAIN_IDLE;
      end
    endcase
  end

  assign busy = (pending_count != '0) | req_in_valid;

endmodule

// File: tb/tb_vx_mem_credit_gate.sv
// Self-checking bench for vx_mem_credit_gate with MAX_PENDING = 4.
// A behavioural model tracks outstanding reads, stall cycles, the sticky
// underflow flag and the drain phase; every falling edge the DUT outputs
// are compared against it. Directed phases pin the model with literal
// expectations, then a randomized phase exercises everything together.
module tb_vx_mem_credit_gate;

  localparam int DS    = 4;
  localparam int AW    = 26;
  localparam int TW    = 8;
  localparam int MAXP  = 4;
  localparam int CW    = $clog2(MAXP + 1);

  logic            clk;
  logic            reset;
  logic            req_in_valid, req_in_rw, req_in_ready;
  logic [AW-1:0]   req_in_addr;
  logic [DS*8-1:0] req_in_data;
  logic [DS-1:0]   req_in_byteen;
  logic [TW-1:0]   req_in_tag;
  logic            req_out_valid, req_out_rw, req_out_ready;
  logic [AW-1:0]   req_out_addr;
  logic [DS*8-1:0] req_out_data;
  logic [DS-1:0]   req_out_byteen;
  logic [TW-1:0]   req_out_tag;
  logic            rsp_in_valid, rsp_in_ready;
  logic [DS*8-1:0] rsp_in_data;
  logic [TW-1:0]   rsp_in_tag;
  logic            rsp_out_valid, rsp_out_ready;
  logic [DS*8-1:0] rsp_out_data;
  logic [TW-1:0]   rsp_out_tag;
  logic            drain_req, drain_ack;
  logic [CW-1:0]   pending_count;
  logic [31:0]     stall_cycles;
  logic            underflow_err;
  logic            busy;

  vx_mem_credit_gate #(
    .DATA_SIZE   (DS),
    .ADDR_WIDTH  (AW),
    .TAG_WIDTH   (TW),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_in_valid   (req_in_valid),
    .req_in_rw      (req_in_rw),
    .req_in_addr    (req_in_addr),
    .req_in_data    (req_in_data),
    .req_in_byteen  (req_in_byteen),
    .req_in_tag     (req_in_tag),
    .req_in_ready   (req_in_ready),
    .req_out_valid  (req_out_valid),
    .req_out_rw     (req_out_rw),
    .req_out_addr   (req_out_addr),
    .req_out_data   (req_out_data),
    .req_out_byteen (req_out_byteen),
    .req_out_tag    (req_out_tag),
    .req_out_ready  (req_out_ready),
    .rsp_in_valid   (rsp_in_valid),
    .rsp_in_data    (rsp_in_data),
    .rsp_in_tag     (rsp_in_tag),
    .rsp_in_ready   (rsp_in_ready),
    .rsp_out_valid  (rsp_out_valid),
    .rsp_out_data   (rsp_out_data),
    .rsp_out_tag    (rsp_out_tag),
    .rsp_out_ready  (rsp_out_ready),
    .drain_req      (drain_req),
    .drain_ack      (drain_ack),
    .pending_count  (pending_count),
    .stall_cycles   (stall_cycles),
    .underflow_err  (underflow_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // drain phase: 0 = running, 1 = draining, 2 = quiesced
  int          m_pend  = 0;
  longint      m_stall = 0;
  bit          m_uf    = 1'b0;
  int          m_phase = 0;
  bit          m_ok    = 1'b0;

  function automatic bit m_block();
    return (m_phase != 0) || (!req_in_rw && m_pend == MAXP);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend  = 0;
      m_stall = 0;
      m_uf    = 1'b0;
      m_phase = 0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      bit issue, giveback;
      int old_pend, nxt;
      issue    = req_in_valid && !req_in_rw && !m_block() && req_out_ready;
      giveback = rsp_in_valid && rsp_out_ready;
      old_pend = m_pend;
      if (giveback && old_pend == 0) m_uf = 1'b1;
      nxt = old_pend + int'(issue) - int'(giveback);
      m_pend = (nxt < 0) ? 0 : nxt;
      if (req_in_valid && !req_in_rw && old_pend == MAXP && m_phase == 0 &&
          m_stall != 64'hFFFF_FFFF)
        m_stall++;
      case (m_phase)
        0: if (drain_req) m_phase = 1;
        1: if (!drain_req) m_phase = 0;
           else if (old_pend == 0 && !giveback) m_phase = 2;
        default: if (!drain_req) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("req_out_valid", 64'(req_out_valid), 64'(req_in_valid && !m_block()));
      check("req_in_ready",  64'(req_in_ready),  64'(req_out_ready && !m_block()));
      check("req_fields",    {req_out_rw, req_out_tag, req_out_byteen, req_out_addr},
                             {req_in_rw, req_in_tag, req_in_byteen, req_in_addr});
      check("req_data",      64'(req_out_data), 64'(req_in_data));
      check("rsp_out_valid", 64'(rsp_out_valid), 64'(rsp_in_valid));
      check("rsp_in_ready",  64'(rsp_in_ready),  64'(rsp_out_ready));
      check("rsp_fields",    {rsp_out_tag, rsp_out_data}, {rsp_in_tag, rsp_in_data});
      check("pending_count", 64'(pending_count), 64'(m_pend));
      check("stall_cycles",  64'(stall_cycles),  64'(m_stall));
      check("underflow_err", 64'(underflow_err), 64'(m_uf));
      check("drain_ack",     64'(drain_ack),     64'(m_phase == 2));
      check("busy",          64'(busy),          64'(m_pend != 0 || req_in_valid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    req_in_addr   = AW'($urandom);
    req_in_data   = $urandom;
    req_in_byteen = DS'($urandom);
    req_in_tag    = TW'($urandom);
    rsp_in_data   = $urandom;
    rsp_in_tag    = TW'($urandom);
  endtask

  initial begin
    int hs;
    reset         = 1'b1;
    req_in_valid  = 1'b1;
    req_in_rw     = 1'b0;
    req_out_ready = 1'b1;
    rsp_in_valid  = 1'b0;
    rsp_out_ready = 1'b1;
    drain_req     = 1'b0;
    rand_fields();

    // Reset state with a read waiting at the input.
    step();
    step();
    @(negedge clk);
    check("lit_rst_pending", 64'(pending_count), 64'd0);
    check("lit_rst_stall",   64'(stall_cycles),  64'd0);
    check("lit_rst_uf",      64'(underflow_err), 64'd0);
    check("lit_rst_ack",     64'(drain_ack),     64'd0);
    check("lit_rst_busy",    64'(busy),          64'd1);
    check("lit_rst_rovalid", 64'(req_out_valid), 64'd1);

    // Six back-to-back reads, no responses: four handshakes then stall.
    step();
    reset = 1'b0;
    hs = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_in_valid && req_in_ready) hs++;
      rand_fields();
      step();
    end
    req_in_valid = 1'b0;
    check("lit_full_handshakes", 64'(hs), 64'd4);
    @(negedge clk);
    check("lit_full_pending", 64'(pending_count), 64'd4);
    check("lit_full_stall",   64'(stall_cycles),  64'd2);

    // Return plus read at full: read waits one cycle, count 4 -> 3 -> 4.
    step();
    rsp_in_valid = 1'b1;
    req_in_valid = 1'b1;
    @(negedge clk);
    check("lit_nobypass_ready", 64'(req_in_ready), 64'd0);
    step();
    rsp_in_valid = 1'b0;
    @(negedge clk);
    check("lit_ret_pending", 64'(pending_count), 64'd3);
    check("lit_ret_ready",   64'(req_in_ready),  64'd1);
    step();
    req_in_valid = 1'b0;
    @(negedge clk);
    check("lit_refill_pending", 64'(pending_count), 64'd4);

    // Ten writes at full all pass and take no credit.
    step();
    req_in_valid = 1'b1;
    req_in_rw    = 1'b1;
    hs = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_in_valid && req_in_ready) hs++;
      rand_fields();
      step();
    end
    req_in_valid = 1'b0;
    req_in_rw    = 1'b0;
    check("lit_writes_passed", 64'(hs), 64'd10);
    @(negedge clk);
    check("lit_writes_pending", 64'(pending_count), 64'd4);

    // Return all four credits.
    rsp_in_valid = 1'b1;
    repeat (4) step();
    rsp_in_valid = 1'b0;
    @(negedge clk);
    check("lit_empty_pending", 64'(pending_count), 64'd0);

    // Underflow: response with nothing outstanding.
    step();
    rsp_in_valid = 1'b1;
    @(negedge clk);
    check("lit_uf_forwarded", 64'(rsp_out_valid), 64'd1);
    step();
    rsp_in_valid = 1'b0;
    @(negedge clk);
    check("lit_uf_set",     64'(underflow_err), 64'd1);
    check("lit_uf_pending", 64'(pending_count), 64'd0);
    repeat (5) step();
    @(negedge clk);
    check("lit_uf_sticky", 64'(underflow_err), 64'd1);

    // Drain with three pending, one return every other cycle.
    step();
    req_in_valid = 1'b1;
    repeat (3) step();
    req_in_valid = 1'b0;
    drain_req    = 1'b1;
    @(negedge clk);
    check("lit_drain_start_pending", 64'(pending_count), 64'd3);
    step();
    req_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rsp_in_valid = (i % 2 == 0);
      @(negedge clk);
      check("lit_drain_blocked", 64'(req_in_ready), 64'd0);
      check("lit_drain_noack",   64'(drain_ack),    64'd0);
      step();
    end
    rsp_in_valid = 1'b0;
    @(negedge clk);
    check("lit_drain_ack", 64'(drain_ack), 64'd1);
    step();
    drain_req    = 1'b0;
    req_in_valid = 1'b0;
    @(negedge clk);
    check("lit_drain_ack_hold", 64'(drain_ack), 64'd1);
    step();
    @(negedge clk);
    check("lit_drain_ack_clear", 64'(drain_ack),    64'd0);
    check("lit_drain_reopen",    64'(req_in_ready), 64'd1);

    // Reset with three pending discards all state.
    step();
    req_in_valid = 1'b1;
    repeat (3) step();
    req_in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("lit_prerst_pending", 64'(pending_count), 64'd3);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("lit_midrst_pending", 64'(pending_count), 64'd0);
    check("lit_midrst_stall",   64'(stall_cycles),  64'd0);
    check("lit_midrst_uf",      64'(underflow_err), 64'd0);
    check("lit_midrst_ack",     64'(drain_ack),     64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_fields();
      req_in_valid  = ($urandom_range(0, 3) != 0);
      req_in_rw     = ($urandom_range(0, 3) == 0);
      req_out_ready = ($urandom_range(0, 4) != 0);
      rsp_in_valid  = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      rsp_out_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
      reset         = ($urandom_range(0, 299) == 0);
    end
    step();
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_mem_credit_gate.md
# vx_mem_credit_gate

Flow-control stage between a socket's L1 memory ports and the cluster-level L2/memory arbiter, one instance per memory port. It limits outstanding read requests to `MAX_PENDING`, returns credits as responses are delivered upstream, and provides a drain handshake that quiesces the port. It also exports pending-count, stall, underflow and busy status to the cluster's busy and perf logic.

## Interface
- `DATA_SIZE`, default 64: line size in bytes; data width is `DATA_SIZE*8`, byte-enable width is `DATA_SIZE`.
- `ADDR_WIDTH`, default 26: line address width.
- `TAG_WIDTH`, default 8: request/response tag width, passed through untouched.
- `MAX_PENDING`, default 16: maximum in-flight reads, ≥1; `CNT_W = $clog2(MAX_PENDING+1)`.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `req_in_valid`, `req_in_rw` (1 = write), `req_in_addr` [ADDR_WIDTH], `req_in_data`, `req_in_byteen`, `req_in_tag` [TAG_WIDTH]: inputs, request from the socket side.
- `req_in_ready` output 1: request accepted from the socket side.
- `req_out_*` outputs, same fields: request toward L2; `req_out_ready` input 1.
- `rsp_in_valid`, `rsp_in_data`, `rsp_in_tag` inputs: read response from L2; `rsp_in_ready` output 1.
- `rsp_out_valid`, `rsp_out_data`, `rsp_out_tag` outputs: response toward the socket; `rsp_out_ready` input 1.
- `drain_req` input 1: request quiescence; `drain_ack` output 1: port is quiesced.
- `pending_count` output CNT_W: reads currently outstanding.
- `stall_cycles` output 32: perf counter of credit stalls.
- `underflow_err` output 1: sticky error flag.
- `busy` output 1: pending_count ≠ 0 or a request is valid at the input.

## Operation
- Request gate:
  - `block = drain_state != IDLE || (!req_in_rw && pending_count == MAX_PENDING)`.
  - `req_out_valid = req_in_valid & !block`.
  - `req_in_ready = req_out_ready & !block`.
  - All request fields pass straight through.
- Credits:
  - A read consumes one credit at the `req_out` handshake.
  - Writes never consume a credit; L2 issues no write responses.
  - A credit is returned at the `rsp_out` handshake.
  - The response path is a straight pass-through: `rsp_out_* = rsp_in_*`, `rsp_in_ready = rsp_out_ready`.
- Counter update: `pending_count += issue_rd - ret`.
  - Simultaneous issue and return leave the count unchanged.
  - A return while the count is 0 leaves the count at 0 and sets `underflow_err`.
  - `underflow_err` clears only on reset.
- Stall counter: `stall_cycles` increments every cycle in which `req_in_valid & !req_in_rw & pending_count == MAX_PENDING & drain_state == IDLE`. It saturates at 0xFFFFFFFF.
- Drain FSM:
  - IDLE: go to DRAIN when `drain_req` = 1.
  - DRAIN: new requests are blocked, both reads and writes. Go to DONE when `pending_count == 0` and no return is occurring this cycle.
  - DONE: `drain_ack` = 1. Go to IDLE when `drain_req` = 0.
  - If `drain_req` deasserts while in DRAIN, go to IDLE without asserting ack.
  - In-flight responses are always drained regardless of state.
- `busy = (pending_count != 0) | req_in_valid`.

## Timing
- Request and response paths have 0-cycle latency; both are combinational.
- `pending_count`, `drain_state` and `stall_cycles` are registered and update at the clock edge following the handshake.
- The credit freed by a return in cycle N is usable by a request in cycle N+1, not in cycle N; there is no same-cycle bypass at full.
- Drain latency: if `pending_count` is 0 when `drain_req` rises in cycle N, the FSM is in DRAIN at N+1 and `drain_ack` = 1 from N+2.
- Reset values:
  - `pending_count` = 0, `stall_cycles` = 0, `underflow_err` = 0.
  - Drain FSM in IDLE, so `drain_ack` = 0.
  - `busy` = `req_in_valid`.
  - `req_out_valid` follows `req_in_valid`, since the count is 0.
- Reset mid-operation discards all credit state. The upstream and L2 reset together with this block, so no stale responses arrive.
- The valid/ready rule is AXI-style: `valid` never depends combinationally on `ready`; `ready` may depend on `valid`.

## Structure
- The drain FSM state enum (IDLE/DRAIN/DONE, 2 bits) goes in `VX_gpu_pkg` as a shared typedef.
- The `CNT_W` derivation stays local to the block.
- One sub-module is natural: `VX_credit_counter` (up/down counter with max and underflow detect), also reused by the other per-port throttles.
- The socket-side instantiation takes a `VX_mem_bus_if` slave and master pair and unpacks it into the flat ports.

## Test plan
- `MAX_PENDING`=4, `req_out_ready`=1, 6 back-to-back reads with no responses: 4 handshakes, then `req_in_ready`=0, `pending_count`=4, `stall_cycles` increments by 1 per cycle while stalled.
- At full (4), one response plus a read request in the same cycle: the read is blocked that cycle and accepted next cycle; `pending_count` goes 4→3→4.
- 10 writes while `pending_count`=4: all pass, and the count stays at 4.
- A response injected while `pending_count`=0: the response is forwarded, the count stays 0, and `underflow_err`=1 persists until reset.
- `drain_req`=1 with 3 pending; return one response every 2 cycles: no new requests accepted, `drain_ack` rises 1 cycle after the count reaches 0, and clears 1 cycle after `drain_req` drops.
- Reset asserted with 3 pending: the next cycle shows `pending_count`=0, FSM in IDLE, `stall_cycles`=0.
